// File: rtl/sn74_updown_counter_n.sv
// sn74_updown_counter_n
// Parametrised synchronous up/down counter with cascade enables, synchronous
// clear/load and three terminal-count behaviours (wrap, saturate, reload).
//
// Ports:
//   clk    rising-edge clock, the only clock for all state
//   nclr   asynchronous active-low reset (q <= RESET_VALUE, wrap <= 0)
//   sclr   synchronous clear, highest synchronous priority
//   nload  synchronous parallel load of d (clamped to MODULUS-1), active-low
//   d      load / auto-reload value
//   enp    parallel count enable
//   ent    trickle count enable, also gates tc
//   up     direction, 1 = up, 0 = down
//   mode   00/11 wrap, 01 saturate, 10 auto-reload
//   q      counter value, always in 0..MODULUS-1
//   tc     combinational terminal count: ent & (q == terminal value)
//   wrap   registered one-cycle pulse following a terminal crossing
module sn74_updown_counter_n #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             nclr,
  input  logic             sclr,
  input  logic             nload,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam int               MAX_I    = MODULUS - 1;
  localparam int               ONE_I    = 1;
  localparam logic [WIDTH-1:0] MAX_V    = MAX_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_V    = ONE_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V    = RESET_VALUE[WIDTH-1:0];
  // One extra bit so MODULUS == 2^WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_V    = MODULUS[WIDTH:0];
  localparam logic [1:0]       MODE_SAT = 2'b01;
  localparam logic [1:0]       MODE_RLD = 2'b10;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] dc_s;
  logic [WIDTH-1:0] tv_s;
  logic             at_tv_s;
  logic             step_s;

  // Out-of-range load values are clamped so q never leaves 0..MODULUS-1.
  assign dc_s    = ({1'b0, d} >= MOD_V) ? MAX_V : d;
  // Terminal value follows the live direction input.
  assign tv_s    = up ? MAX_V : {WIDTH{1'b0}};
  assign at_tv_s = (count_q == tv_s);
  assign step_s  = enp & ent;

  assign q    = count_q;
  assign tc   = ent & at_tv_s;
  assign wrap = wrap_q;

  // Next-state selection in priority order: clear, load, count step, hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (sclr) begin
      count_d = {WIDTH{1'b0}};
    end else if (!nload) begin
      count_d = dc_s;
    end else if (step_s) begin
      if (!at_tv_s) begin
        // Away from the terminal value a step can never leave the range.
        count_d = up ? (count_q + ONE_V) : (count_q - ONE_V);
      end else begin
        case (mode)
          MODE_SAT: begin
            count_d = count_q;
          end
          MODE_RLD: begin
            count_d = dc_s;
            wrap_d  = 1'b1;
          end
          default: begin
            count_d = up ? {WIDTH{1'b0}} : MAX_V;
            wrap_d  = 1'b1;
          end
        endcase
      end
    end else begin
      count_d = count_q;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      count_q <= RST_V;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_sn74_updown_counter_n.sv
// Self-checking bench for sn74_updown_counter_n. Two instances share every
// input: a decade counter (MODULUS=10, RESET_VALUE=3) and a full-range one
// (MODULUS=16, RESET_VALUE=0). A behavioural model in plain integer
// arithmetic predicts q and wrap of both; tc is derived from the model q.
module tb_sn74_updown_counter_n;

  logic       clk;
  logic       nclr;
  logic       sclr;
  logic       nload;
  logic [3:0] d;
  logic       enp;
  logic       ent;
  logic       up;
  logic [1:0] mode;
  logic [3:0] q10, q16;
  logic       tc10, tc16;
  logic       wrap10, wrap16;

  int errors;
  int checks;
  int mq[2];
  int mw[2];
  int modv[2];
  int rstv[2];

  sn74_updown_counter_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut10 (
    .clk(clk), .nclr(nclr), .sclr(sclr), .nload(nload), .d(d),
    .enp(enp), .ent(ent), .up(up), .mode(mode),
    .q(q10), .tc(tc10), .wrap(wrap10)
  );

  sn74_updown_counter_n #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut16 (
    .clk(clk), .nclr(nclr), .sclr(sclr), .nload(nload), .d(d),
    .enp(enp), .ent(ent), .up(up), .mode(mode),
    .q(q16), .tc(tc16), .wrap(wrap16)
  );

  always #5 clk = ~clk;

  // Expected {q, wrap, tc} of instance k from the model state and live inputs.
  function automatic logic [5:0] expv(int k);
    int  qq;
    logic t;
    qq = mq[k];
    t  = ent && (up ? (qq == modv[k] - 1) : (qq == 0));
    return {qq[3:0], mw[k][0], t};
  endfunction

  // Advance the model by one edge using the inputs as they stand, then clock.
  task automatic tick();
    int nq[2];
    int nw[2];
    for (int k = 0; k < 2; k++) begin
      int m, dc, cur;
      m   = modv[k];
      cur = mq[k];
      dc  = (int'(d) >= m) ? m - 1 : int'(d);
      nq[k] = cur;
      nw[k] = 0;
      if (sclr) begin
        nq[k] = 0;
      end else if (!nload) begin
        nq[k] = dc;
      end else if (enp && ent) begin
        if (cur != (up ? m - 1 : 0)) begin
          nq[k] = up ? (cur + 1) % m : (cur + m - 1) % m;
        end else if (mode == 2'b01) begin
          nq[k] = cur;
        end else if (mode == 2'b10) begin
          nq[k] = dc;
          nw[k] = 1;
        end else begin
          nq[k] = up ? (cur + 1) % m : (cur + m - 1) % m;
          nw[k] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    mq = nq;
    mw = nw;
  endtask

  task automatic set_idle();
    sclr = 1'b0; nload = 1'b1; d = 4'd0; enp = 1'b0; ent = 1'b0;
    up = 1'b1; mode = 2'b00;
  endtask

  task automatic test_reset();
    set_idle();
    nclr = 1'b0;
    #12;
    checks++;
    if ({q10, wrap10} !== {4'd3, 1'b0}) begin
      errors++; $display("FAIL reset_init10 got q=%0d wrap=%0b exp q=3 wrap=0", q10, wrap10);
    end
    checks++;
    if ({q16, wrap16} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_init16 got q=%0d wrap=%0b exp q=0 wrap=0", q16, wrap16);
    end
    @(negedge clk);
    nclr = 1'b1;
    mq[0] = rstv[0]; mq[1] = rstv[1]; mw[0] = 0; mw[1] = 0;
    ent = 1'b1;
    #1;
    checks++;
    if (tc10 !== 1'b0) begin
      errors++; $display("FAIL reset_tc10 got %0b exp 0", tc10);
    end
    // Put a wrap pulse in flight, then reset between edges.
    nload = 1'b0; d = 4'd9;
    tick();
    nload = 1'b1; enp = 1'b1;
    tick();
    checks++;
    if ({q10, wrap10, tc10} !== expv(0) || wrap10 !== 1'b1) begin
      errors++; $display("FAIL reset_prewrap got q=%0d w=%0b tc=%0b exp %h", q10, wrap10, tc10, expv(0));
    end
    #2;
    nclr = 1'b0;
    #1;
    checks++;
    if ({q10, wrap10, q16, wrap16} !== {4'd3, 1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_async got q10=%0d w10=%0b q16=%0d w16=%0b exp 3 0 0 0", q10, wrap10, q16, wrap16);
    end
    #1;
    nclr = 1'b1;
    mq[0] = rstv[0]; mq[1] = rstv[1]; mw[0] = 0; mw[1] = 0;
    set_idle();
  endtask

  task automatic test_decade_wrap();
    sclr = 1'b1;
    tick();
    sclr = 1'b0; mode = 2'b00; up = 1'b1; enp = 1'b1; ent = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if ({q10, wrap10, tc10} !== expv(0)) begin
        errors++; $display("FAIL decade10 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q10, wrap10, tc10, expv(0));
      end
      checks++;
      if ({q16, wrap16, tc16} !== expv(1)) begin
        errors++; $display("FAIL decade16 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q16, wrap16, tc16, expv(1));
      end
    end
    set_idle();
  endtask

  task automatic test_down_reload();
    nload = 1'b0; d = 4'd2;
    tick();
    nload = 1'b1; d = 4'd6; mode = 2'b10; up = 1'b0; enp = 1'b1; ent = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({q10, wrap10, tc10} !== expv(0)) begin
        errors++; $display("FAIL reload10 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q10, wrap10, tc10, expv(0));
      end
      checks++;
      if ({q16, wrap16, tc16} !== expv(1)) begin
        errors++; $display("FAIL reload16 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q16, wrap16, tc16, expv(1));
      end
    end
    set_idle();
  endtask

  task automatic test_saturate();
    sclr = 1'b1;
    tick();
    sclr = 1'b0; mode = 2'b01; up = 1'b1; enp = 1'b1; ent = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({q10, wrap10, tc10} !== expv(0)) begin
        errors++; $display("FAIL sat10 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q10, wrap10, tc10, expv(0));
      end
      checks++;
      if ({q16, wrap16, tc16} !== expv(1)) begin
        errors++; $display("FAIL sat16 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q16, wrap16, tc16, expv(1));
      end
    end
    ent = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({q10, wrap10, tc10} !== {4'd9, 1'b0, 1'b0} || {q10, wrap10, tc10} !== expv(0)) begin
        errors++; $display("FAIL sat_ent0 cyc=%0d got q=%0d w=%0b tc=%0b exp q=9 w=0 tc=0", i, q10, wrap10, tc10);
      end
    end
    set_idle();
  endtask

  task automatic test_load_priority();
    nload = 1'b0; d = 4'hC;
    tick();
    checks++;
    if ({q10, q16} !== {4'd9, 4'd12}) begin
      errors++; $display("FAIL load_clamp got q10=%0d q16=%0d exp 9 12", q10, q16);
    end
    sclr = 1'b1;
    tick();
    checks++;
    if ({q10, q16, wrap10, wrap16} !== {4'd0, 4'd0, 2'b00}) begin
      errors++; $display("FAIL clr_over_load got q10=%0d q16=%0d exp 0 0", q10, q16);
    end
    sclr = 1'b0; d = 4'd5; enp = 1'b1; ent = 1'b1;
    tick();
    checks++;
    if ({q10, q16, wrap10} !== {4'd5, 4'd5, 1'b0} || {q10, wrap10, tc10} !== expv(0)) begin
      errors++; $display("FAIL load_over_step got q10=%0d q16=%0d exp 5 5", q10, q16);
    end
    set_idle();
  endtask

  task automatic test_full_range();
    sclr = 1'b1;
    tick();
    sclr = 1'b0; mode = 2'b00; up = 1'b0; enp = 1'b1; ent = 1'b1;
    tick();
    checks++;
    if ({q16, wrap16, tc16} !== {4'd15, 1'b1, 1'b0} || {q16, wrap16, tc16} !== expv(1)) begin
      errors++; $display("FAIL full_down16 got q=%0d w=%0b tc=%0b exp q=15 w=1 tc=0", q16, wrap16, tc16);
    end
    checks++;
    if ({q10, wrap10} !== {4'd9, 1'b1}) begin
      errors++; $display("FAIL full_down10 got q=%0d w=%0b exp q=9 w=1", q10, wrap10);
    end
    up = 1'b1;
    #1;
    checks++;
    if ({tc16, tc10} !== 2'b11) begin
      errors++; $display("FAIL dir_flip_tc got tc16=%0b tc10=%0b exp 1 1", tc16, tc10);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sclr  = ($urandom_range(0, 19) == 0);
      nload = ($urandom_range(0, 9) != 0);
      d     = 4'($urandom_range(0, 15));
      enp   = ($urandom_range(0, 3) != 0);
      ent   = ($urandom_range(0, 3) != 0);
      up    = ($urandom_range(0, 2) != 0);
      mode  = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if ({q10, wrap10, tc10} !== expv(0)) begin
        errors++; $display("FAIL rand10 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q10, wrap10, tc10, expv(0));
      end
      checks++;
      if ({q16, wrap16, tc16} !== expv(1)) begin
        errors++; $display("FAIL rand16 cyc=%0d got q=%0d w=%0b tc=%0b exp %h", i, q16, wrap16, tc16, expv(1));
      end
    end
    set_idle();
  endtask

  initial begin
    clk = 1'b0;
    errors = 0;
    checks = 0;
    modv[0] = 10; modv[1] = 16;
    rstv[0] = 3;  rstv[1] = 0;
    mq[0] = 3; mq[1] = 0; mw[0] = 0; mw[1] = 0;
    test_reset();
    test_decade_wrap();
    test_down_reload();
    test_saturate();
    test_load_priority();
    test_full_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sn74_updown_counter_n.md
# sn74_updown_counter_n

Parametrised synchronous up/down counter. It is the successor to the library's 4-bit asynchronous-clocked up/down counter.
- Width and count modulus are configurable; one clock drives all state.
- Adds cascade enables, synchronous load and clear, and three terminal-count modes: wrap, saturate and auto-reload.
- Used as a divider, a timer or a cascadable counter stage wherever the 74-series counter models are instantiated.

## Interface
Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2^WIDTH.
- RESET_VALUE, 0: value of q after reset. Must be < MODULUS.

Ports:
- clk  in  1  clock, rising edge active.
- nclr  in  1  reset; asynchronous, active-low.
- sclr  in  1  synchronous clear, active-high.
- nload  in  1  synchronous parallel load, active-low.
- d  in  WIDTH  load / reload value.
- enp  in  1  count enable (parallel).
- ent  in  1  count enable (trickle). Also gates tc.
- up  in  1  direction: 1 = up, 0 = down.
- mode  in  2  terminal behaviour: 00 wrap, 01 saturate, 10 auto-reload, 11 treated as 00.
- q  out  WIDTH  counter value.
- tc  out  1  terminal count, combinational.
- wrap  out  1  registered one-cycle pulse marking a terminal crossing.

## Operation
- Terminal value TV:
  - TV = MODULUS-1 when up=1.
  - TV = 0 when up=0.
- tc = ent & (q == TV). tc is combinational from q, up and ent. Cascade by driving the next stage's ent from this stage's tc.
- Clamped load value dc = (d >= MODULUS) ? MODULUS-1 : d.
- Per-edge priority, highest first:
  - nclr low (async): q <= RESET_VALUE, wrap <= 0.
  - sclr=1: q <= 0, wrap <= 0.
  - nload=0: q <= dc, wrap <= 0.
  - enp & ent = 1 (a count step):
    - q != TV: q <= q+1 (up) or q-1 (down); wrap <= 0.
    - q == TV, mode 00/11: q <= 0 (up) or MODULUS-1 (down); wrap <= 1.
    - q == TV, mode 01: q holds; wrap <= 0.
    - q == TV, mode 10: q <= dc; wrap <= 1.
  - Otherwise: q holds; wrap <= 0.
- Arithmetic is modulo MODULUS, never modulo 2^WIDTH. No intermediate value >= MODULUS is ever stored in q.
- Changes to up, mode and d are sampled at the edge; there is no latching or hysteresis.
- The enables and direction are independent. Toggling up while at TV moves TV immediately, so tc updates in the same cycle.

## Timing
- Reset values: q = RESET_VALUE, wrap = 0. tc = ent & (RESET_VALUE == TV).
- Assertion of nclr takes effect immediately, without waiting for a clock edge. Release is synchronised by the user. The first edge after release may count.
- Reset in mid-operation (any mode, any q) aborts the state. A wrap pulse in flight is cleared at once.
- q latency: 1 clock from sampled controls.
- tc latency: 0 clocks from q, up and ent.
- wrap latency: 1 clock. wrap is high for exactly the cycle following the crossing edge. Back-to-back crossings (e.g. MODULUS=2, continuous enable, up) give wrap high every other cycle.
- Simultaneous events resolve by the priority list above:
  - sclr with nload=0: clear wins.
  - nload=0 with count enabled: load wins, no step.
- Saturate mode with continuous enable at TV: q and tc stay constant; wrap stays 0.

## Test plan
- Reset: WIDTH=4, MODULUS=10, RESET_VALUE=3, nclr pulsed low between edges -> q=3 immediately, wrap=0. With up=1, ent=1: tc=0.
- Decade wrap up: mode=00, up=1, enp=ent=1 from q=0 -> q counts 0..9. tc=1 while q=9. Next edge q=0, wrap=1 for one cycle. Repeats every 10 clocks.
- Down, auto-reload: mode=10, up=0, d=6, start q=2 -> 2,1,0,6,5... wrap=1 in the cycle q first reads 6. tc=1 only at q=0.
- Saturate and cascade: mode=01, up=1 -> q stops at 9, tc held 1, wrap never asserts. Dropping ent to 0 -> tc=0 and q frozen even with enp=1.
- Load clamp and priority:
  - nload=0, d=4'hC, MODULUS=10 -> q=9.
  - sclr=1 and nload=0 together -> q=0.
  - nload=0 with enp=ent=1, d=5 -> q=5, no step.
- Full range: WIDTH=4, MODULUS=16, up=0 from q=0, mode=00 -> q=15, wrap=1. Direction flipped at q=15 -> tc goes 0 to 1 in the same cycle.
